// File: rtl/data_sram_responder_pkg.sv
// Shared widths, FSM encodings and stall levels for the data SRAM responder.
package data_sram_responder_pkg;

  localparam int DSRAM_DATA_WD = 32;
  localparam int DSRAM_WEN_WD  = 4;

  typedef enum logic [1:0] {
    DSRAM_IDLE = 2'd0,
    DSRAM_WAIT = 2'd1,
    DSRAM_RESP = 2'd2
  } dsram_state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/data_sram_responder_dsram_bank.sv
// Word-addressed storage with per-byte-lane writes and a registered read port.
module data_sram_responder_dsram_bank
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DSRAM_WEN_WD-1:0]  wr_be,
  input  logic [ADDR_W-1:0]        wr_idx,
  input  logic [DSRAM_DATA_WD-1:0] wr_data,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [ADDR_W-1:0]        rd_idx,
  output logic [DSRAM_DATA_WD-1:0] rd_data
);

  logic [DSRAM_DATA_WD-1:0] mem_q [2**ADDR_W];
  logic [DSRAM_DATA_WD-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DSRAM_WEN_WD; i++) begin
      if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Read register holds its value between reads; rd_zero forces an empty word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else if (rd_en) rd_data_q <= rd_zero ? '0 : mem_q[rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM slave: request FSM, wait-state counter and stall request.
// Optional range checking is enabled by defining DSRAM_ADDR_CHECK_EN.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          WAIT_CYC  = 0,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_sram_en,
  input  logic [DSRAM_WEN_WD-1:0]  data_sram_wen,
  input  logic [31:0]              data_sram_addr,
  input  logic [DSRAM_DATA_WD-1:0] data_sram_wdata,
  output logic [DSRAM_DATA_WD-1:0] data_sram_rdata,
  output logic                     stallreq,
  output logic                     addr_err
);

  dsram_state_e             state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [ADDR_W-1:0]        ridx_q, ridx_d;
  logic                     rzero_q, rzero_d;
  logic                     addr_err_q, addr_err_d;

  logic [31:0]              offset;
  logic [ADDR_W-1:0]        idx;
  logic                     out_of_range;
  logic [DSRAM_WEN_WD-1:0]  wr_be;
  logic                     rd_en, rd_zero, stall_c;
  logic [ADDR_W-1:0]        rd_idx;

  assign offset = data_sram_addr - BASE_ADDR;
  assign idx    = ADDR_W'(offset >> 2);

`ifdef DSRAM_ADDR_CHECK_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd4 << ADDR_W);
  assign out_of_range = (data_sram_addr < BASE_ADDR) || ({1'b0, data_sram_addr} >= LIMIT);
`else
  // Without range checking the flag can never be raised and addresses wrap.
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ridx_d     = ridx_q;
    rzero_d    = rzero_q;
    addr_err_d = 1'b0;
    wr_be      = '0;
    rd_en      = 1'b0;
    rd_zero    = 1'b0;
    rd_idx     = idx;
    stall_c    = NoStop;
    case (state_q)
      DSRAM_IDLE: begin
        if (data_sram_en && !rst) begin
          addr_err_d = out_of_range;
          if (data_sram_wen != '0) begin
            if (!out_of_range) wr_be = data_sram_wen;
          end else if (WAIT_CYC <= 1) begin
            rd_en   = 1'b1;
            rd_zero = out_of_range;
            if (WAIT_CYC == 1) begin
              stall_c = Stop;
              state_d = DSRAM_RESP;
            end
          end else begin
            // The accept cycle is the first of the WAIT_CYC stall cycles.
            stall_c = Stop;
            ridx_d  = idx;
            rzero_d = out_of_range;
            cnt_d   = 4'(WAIT_CYC - 1);
            state_d = DSRAM_WAIT;
          end
        end
      end
      DSRAM_WAIT: begin
        stall_c = Stop;
        if (cnt_q == 4'd1) begin
          rd_en   = 1'b1;
          rd_idx  = ridx_q;
          rd_zero = rzero_q;
          cnt_d   = '0;
          state_d = DSRAM_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DSRAM_RESP: state_d = DSRAM_IDLE;
      default:    state_d = DSRAM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DSRAM_IDLE;
      cnt_q      <= '0;
      ridx_q     <= '0;
      rzero_q    <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ridx_q     <= ridx_d;
      rzero_q    <= rzero_d;
      addr_err_q <= addr_err_d;
    end
  end

  data_sram_responder_dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_be   (wr_be),
    .wr_idx  (idx),
    .wr_data (data_sram_wdata),
    .rd_en   (rd_en),
    .rd_zero (rd_zero),
    .rd_idx  (rd_idx),
    .rd_data (data_sram_rdata)
  );

  assign stallreq = rst ? NoStop : stall_c;
  assign addr_err = addr_err_q;

endmodule
